// File: rtl/mips32_pipe_fwd.sv
// mips32_pipe_fwd
//   Single-clock five-stage (IF/ID/EX/MEM/WB) in-order MIPS32-subset core.
//   Hazards are handled in hardware. FWD_EN=1 selects EX/MEM and MEM/WB
//   bypassing plus a one-cycle load-use stall. FWD_EN=0 selects a pure
//   interlock on a write-first register file. Taken branches resolve in EX
//   and squash the two younger instructions.
//
// Ports
//   clk1        sole clock, rising edge
//   rst_n       asynchronous active-low reset (pipeline, pc, regs, counters)
//   run         1 = pipeline advances; 0 = frozen, program port enabled
//   prog_we     memory write strobe (only while run=0)
//   prog_addr   memory write address
//   prog_wdata  memory write data
//   dbg_raddr   register-file debug read address
//   dbg_rdata   Reg[dbg_raddr], combinational, R0 reads 0
//   pc          current fetch address
//   halted      HLT has retired; all state frozen until reset
//   retired     count of valid instructions that left WB
module mips32_pipe_fwd #(
  parameter int DW        = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int FWD_EN    = 1,
  localparam int AW       = $clog2(MEM_DEPTH)
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          run,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_wdata,
  input  logic [4:0]    dbg_raddr,
  output logic [DW-1:0] dbg_rdata,
  output logic [AW-1:0] pc,
  output logic          halted,
  output logic [31:0]   retired
);

  localparam int   MW      = (DW > 32) ? DW : 32;
  localparam logic USE_FWD = (FWD_EN != 0);

  typedef enum logic [5:0] {
    OP_ADD   = 6'b000000,
    OP_SUB   = 6'b000001,
    OP_AND   = 6'b000010,
    OP_OR    = 6'b000011,
    OP_SLT   = 6'b000100,
    OP_MUL   = 6'b000101,
    OP_LW    = 6'b001000,
    OP_SW    = 6'b001001,
    OP_ADDI  = 6'b001010,
    OP_SUBI  = 6'b001011,
    OP_SLTI  = 6'b001100,
    OP_BNEQZ = 6'b001101,
    OP_BEQZ  = 6'b001110,
    OP_HLT   = 6'b111111
  } opcode_t;

  // Storage
  logic [MW-1:0] mem  [MEM_DEPTH];
  logic [DW-1:0] regs [32];

  // IF/ID
  logic          ifid_valid;
  logic [31:0]   ifid_ir;
  logic [AW-1:0] ifid_npc;
  logic          fetch_stop;

  // ID/EX
  logic          idex_valid;
  opcode_t       idex_op;
  logic [DW-1:0] idex_a, idex_b, idex_imm;
  logic [AW-1:0] idex_npc;
  logic [4:0]    idex_rs, idex_rt, idex_dest;
  logic          idex_wr;

  // EX/MEM
  logic          exmem_valid;
  logic [DW-1:0] exmem_alu, exmem_b;
  logic [4:0]    exmem_dest;
  logic          exmem_wr, exmem_lw, exmem_sw, exmem_hlt;

  // MEM/WB
  logic          memwb_valid;
  logic [DW-1:0] memwb_val;
  logic [4:0]    memwb_dest;
  logic          memwb_wr, memwb_hlt;

  logic adv;
  assign adv = run && !halted;

  // ---------------- IF ----------------
  logic [MW-1:0] if_word;
  logic [31:0]   if_ir;
  assign if_word = mem[pc];
  assign if_ir   = if_word[31:0];

  // ---------------- ID ----------------
  opcode_t       id_op;
  logic [4:0]    id_rs, id_rt, id_rd, id_dest;
  logic [DW-1:0] id_imm, id_a, id_b;
  logic          id_rr, id_rm, id_reads_rs, id_reads_rt, id_wr, id_hlt;

  assign id_rs  = ifid_ir[25:21];
  assign id_rt  = ifid_ir[20:16];
  assign id_rd  = ifid_ir[15:11];
  assign id_imm = DW'($signed(ifid_ir[15:0]));

  always_comb begin
    id_op = OP_HLT;
    id_rr = 1'b0;
    id_rm = 1'b0;
    case (ifid_ir[31:26])
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL,
      OP_LW, OP_SW, OP_ADDI, OP_SUBI, OP_SLTI, OP_BNEQZ, OP_BEQZ:
        id_op = opcode_t'(ifid_ir[31:26]);
      default: id_op = OP_HLT;
    endcase
    case (id_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: id_rr = 1'b1;
      OP_ADDI, OP_SUBI, OP_SLTI:                     id_rm = 1'b1;
      default: ;
    endcase
  end

  assign id_reads_rs = (id_op != OP_HLT);
  assign id_reads_rt = id_rr || (id_op == OP_SW);
  assign id_dest     = id_rr ? id_rd : id_rt;
  assign id_wr       = (id_rr || id_rm || (id_op == OP_LW)) && (id_dest != 5'd0);
  assign id_hlt      = ifid_valid && (id_op == OP_HLT);

  // Write-first read: the value leaving WB this cycle is seen by ID.
  assign id_a = (id_rs == 5'd0) ? '0 :
                (memwb_valid && memwb_wr && memwb_dest == id_rs) ? memwb_val : regs[id_rs];
  assign id_b = (id_rt == 5'd0) ? '0 :
                (memwb_valid && memwb_wr && memwb_dest == id_rt) ? memwb_val : regs[id_rt];

  // Hazard detection; wr flags already exclude R0 destinations.
  logic hit_ex, hit_mem, ld_use, interlock, stall;
  assign hit_ex  = idex_valid && idex_wr &&
                   ((id_reads_rs && id_rs == idex_dest) || (id_reads_rt && id_rt == idex_dest));
  assign hit_mem = exmem_valid && exmem_wr &&
                   ((id_reads_rs && id_rs == exmem_dest) || (id_reads_rt && id_rt == exmem_dest));
  assign ld_use    = USE_FWD && ifid_valid && hit_ex && (idex_op == OP_LW);
  assign interlock = !USE_FWD && ifid_valid && (hit_ex || hit_mem);
  assign stall     = ld_use || interlock;

  // ---------------- EX ----------------
  logic [DW-1:0] ex_a, ex_b, ex_alu;
  logic          ex_taken;
  logic [AW-1:0] ex_target;

  always_comb begin
    ex_a = idex_a;
    ex_b = idex_b;
    if (USE_FWD) begin
      if (exmem_valid && exmem_wr && !exmem_lw && exmem_dest == idex_rs)
        ex_a = exmem_alu;
      else if (memwb_valid && memwb_wr && memwb_dest == idex_rs)
        ex_a = memwb_val;
      if (exmem_valid && exmem_wr && !exmem_lw && exmem_dest == idex_rt)
        ex_b = exmem_alu;
      else if (memwb_valid && memwb_wr && memwb_dest == idex_rt)
        ex_b = memwb_val;
    end
  end

  always_comb begin
    ex_alu = '0;
    case (idex_op)
      OP_ADD:       ex_alu = ex_a + ex_b;
      OP_SUB:       ex_alu = ex_a - ex_b;
      OP_AND:       ex_alu = ex_a & ex_b;
      OP_OR:        ex_alu = ex_a | ex_b;
      OP_SLT:       ex_alu = DW'(ex_a < ex_b);
      OP_MUL:       ex_alu = ex_a * ex_b;
      OP_ADDI:      ex_alu = ex_a + idex_imm;
      OP_SUBI:      ex_alu = ex_a - idex_imm;
      OP_SLTI:      ex_alu = DW'(ex_a < idex_imm);
      OP_LW, OP_SW: ex_alu = ex_a + idex_imm;
      default:      ex_alu = '0;
    endcase
  end

  assign ex_taken  = idex_valid &&
                     (((idex_op == OP_BNEQZ) && (ex_a != '0)) ||
                      ((idex_op == OP_BEQZ)  && (ex_a == '0)));
  assign ex_target = idex_npc + idex_imm[AW-1:0];

  // ---------------- MEM ----------------
  logic [MW-1:0] mem_word;
  logic [DW-1:0] mem_val;
  assign mem_word = mem[exmem_alu[AW-1:0]];
  assign mem_val  = exmem_lw ? mem_word[DW-1:0] : exmem_alu;

  // ---------------- Pipeline registers ----------------
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= '0;
      halted      <= 1'b0;
      retired     <= '0;
      fetch_stop  <= 1'b0;
      ifid_valid  <= 1'b0;
      ifid_ir     <= '0;
      ifid_npc    <= '0;
      idex_valid  <= 1'b0;
      idex_op     <= OP_ADD;
      idex_a      <= '0;
      idex_b      <= '0;
      idex_imm    <= '0;
      idex_npc    <= '0;
      idex_rs     <= '0;
      idex_rt     <= '0;
      idex_dest   <= '0;
      idex_wr     <= 1'b0;
      exmem_valid <= 1'b0;
      exmem_alu   <= '0;
      exmem_b     <= '0;
      exmem_dest  <= '0;
      exmem_wr    <= 1'b0;
      exmem_lw    <= 1'b0;
      exmem_sw    <= 1'b0;
      exmem_hlt   <= 1'b0;
      memwb_valid <= 1'b0;
      memwb_val   <= '0;
      memwb_dest  <= '0;
      memwb_wr    <= 1'b0;
      memwb_hlt   <= 1'b0;
    end else if (adv) begin
      // WB retirement
      if (memwb_valid) begin
        retired <= retired + 32'd1;
        if (memwb_hlt) halted <= 1'b1;
      end

      // MEM -> WB
      memwb_valid <= exmem_valid;
      memwb_val   <= mem_val;
      memwb_dest  <= exmem_dest;
      memwb_wr    <= exmem_wr;
      memwb_hlt   <= exmem_hlt;

      // EX -> MEM
      exmem_valid <= idex_valid;
      exmem_alu   <= ex_alu;
      exmem_b     <= ex_b;
      exmem_dest  <= idex_dest;
      exmem_wr    <= idex_wr;
      exmem_lw    <= (idex_op == OP_LW);
      exmem_sw    <= (idex_op == OP_SW);
      exmem_hlt   <= (idex_op == OP_HLT);

      // ID -> EX: payload always loads; valid gates its effect
      idex_valid <= ifid_valid && !ex_taken && !stall;
      idex_op    <= id_op;
      idex_a     <= id_a;
      idex_b     <= id_b;
      idex_imm   <= id_imm;
      idex_npc   <= ifid_npc;
      idex_rs    <= id_rs;
      idex_rt    <= id_rt;
      idex_dest  <= id_dest;
      idex_wr    <= id_wr;

      // IF -> ID
      if (ex_taken) begin
        ifid_valid <= 1'b0;
        pc         <= ex_target;
      end else if (!stall) begin
        if (fetch_stop || id_hlt) begin
          ifid_valid <= 1'b0;
        end else begin
          ifid_valid <= 1'b1;
          ifid_ir    <= if_ir;
          ifid_npc   <= pc + 1'b1;
          pc         <= pc + 1'b1;
        end
      end

      // Once HLT leaves ID nothing older can squash it, so fetch stays off.
      if (!ex_taken && !stall && id_hlt) fetch_stop <= 1'b1;
    end
  end

  // Register file
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (adv && memwb_valid && memwb_wr) begin
      regs[memwb_dest] <= memwb_val;
    end
  end

  // Unified memory: not reset; program port owns it while frozen.
  always_ff @(posedge clk1) begin
    if (!run) begin
      if (prog_we) mem[prog_addr] <= MW'(prog_wdata);
    end else if (rst_n && adv && exmem_valid && exmem_sw) begin
      mem[exmem_alu[AW-1:0]] <= MW'(exmem_b);
    end
  end

  assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : regs[dbg_raddr];

endmodule

// File: tb/tb_mips32_pipe_fwd.sv
// tb_mips32_pipe_fwd
//   Directed bench driving a forwarding core (FWD_EN=1) and an interlock core
//   (FWD_EN=0) in lockstep with the same program images and comparing both
//   against hand-computed register values, retire counts and halt edges.
module tb_mips32_pipe_fwd;

  localparam int DW = 32;
  localparam int AW = 10;

  localparam logic [5:0] OP_ADD = 6'b000000, OP_MUL = 6'b000101,
                         OP_LW = 6'b001000, OP_SW = 6'b001001,
                         OP_ADDI = 6'b001010, OP_SUBI = 6'b001011,
                         OP_BNEQZ = 6'b001101;
  localparam logic [31:0] W_HLT = 32'hFC00_0000;

  logic          clk1 = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [31:0]   prog_wdata = '0;
  logic [4:0]    dbg_raddr = '0;
  logic [DW-1:0] dbg_f, dbg_i;
  logic [AW-1:0] pc_f, pc_i;
  logic          halt_f, halt_i;
  logic [31:0]   ret_f, ret_i;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] prog_buf [16];

  always #5 clk1 = ~clk1;

  mips32_pipe_fwd #(.DW(DW), .MEM_DEPTH(1024), .FWD_EN(1)) dut_fwd (
    .clk1(clk1), .rst_n(rst_n), .run(run), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .dbg_raddr(dbg_raddr),
    .dbg_rdata(dbg_f), .pc(pc_f), .halted(halt_f), .retired(ret_f));

  mips32_pipe_fwd #(.DW(DW), .MEM_DEPTH(1024), .FWD_EN(0)) dut_il (
    .clk1(clk1), .rst_n(rst_n), .run(run), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .dbg_raddr(dbg_raddr),
    .dbg_rdata(dbg_i), .pc(pc_i), .halted(halt_i), .retired(ret_i));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] enc_rr(input logic [5:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] enc_ri(input logic [5:0] op, input logic [4:0] rt,
                                         input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic poke(input int addr, input logic [31:0] data);
    @(negedge clk1);
    run = 1'b0; prog_we = 1'b1; prog_addr = AW'(addr); prog_wdata = data;
    @(negedge clk1);
    prog_we = 1'b0;
  endtask

  task automatic load_prog(input int n);
    for (int i = 0; i < n; i++) poke(i, prog_buf[i]);
  endtask

  task automatic apply_reset();
    @(negedge clk1);
    run = 1'b0; rst_n = 1'b0;
    @(negedge clk1);
    rst_n = 1'b1;
  endtask

  task automatic read_regs(input logic [4:0] a, output logic [DW-1:0] vf,
                           output logic [DW-1:0] vi);
    dbg_raddr = a;
    #1;
    vf = dbg_f; vi = dbg_i;
  endtask

  // Runs until both cores halt or the budget expires (-1 = never halted).
  // hf/hi give the 0-based active edge after which halted was seen.
  task automatic run_prog(input int pause_at, output int hf, output int hi,
                          output logic [AW-1:0] ppf, output logic [AW-1:0] ppi);
    int active;
    hf = -1; hi = -1; active = 0; ppf = '0; ppi = '0;
    @(negedge clk1);
    run = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk1);
      #1;
      if (halt_f && hf < 0) hf = active;
      if (halt_i && hi < 0) hi = active;
      active++;
      if (hf >= 0 && hi >= 0) break;
      if (active == pause_at) begin
        @(negedge clk1);
        run = 1'b0;
        repeat (5) @(negedge clk1);
        ppf = pc_f; ppi = pc_i;
        run = 1'b1;
      end
    end
    @(negedge clk1);
    run = 1'b0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] vf, vi;
    apply_reset();
    #1;
    n_checks++;
    if (pc_f !== '0 || pc_i !== '0) $display("FAIL reset_pc fwd=%0d il=%0d expected=0", pc_f, pc_i);
    else n_pass++;
    n_checks++;
    if (halt_f !== 1'b0 || halt_i !== 1'b0) $display("FAIL reset_halted fwd=%0b il=%0b expected=0", halt_f, halt_i);
    else n_pass++;
    n_checks++;
    if (ret_f !== '0 || ret_i !== '0) $display("FAIL reset_retired fwd=%0d il=%0d expected=0", ret_f, ret_i);
    else n_pass++;
    for (int r = 0; r < 32; r++) begin
      read_regs(5'(r), vf, vi);
      n_checks++;
      if (vf !== '0 || vi !== '0) $display("FAIL reset_reg%0d fwd=%0d il=%0d expected=0", r, vf, vi);
      else n_pass++;
    end
  endtask

  task automatic load_alu_chain();
    prog_buf[0] = enc_ri(OP_ADDI, 5'd1, 5'd0, 16'd10);
    prog_buf[1] = enc_ri(OP_ADDI, 5'd2, 5'd0, 16'd20);
    prog_buf[2] = enc_rr(OP_ADD, 5'd3, 5'd1, 5'd2);
    prog_buf[3] = enc_rr(OP_MUL, 5'd4, 5'd3, 5'd3);
    prog_buf[4] = W_HLT;
    load_prog(5);
  endtask

  task automatic test_alu_chain();
    int hf, hi;
    logic [AW-1:0] pf, pi;
    logic [DW-1:0] vf, vi;
    load_alu_chain();
    apply_reset();
    run_prog(0, hf, hi, pf, pi);
    n_checks++;
    if (hf !== 8 || hi !== 12) $display("FAIL alu_halt_edge fwd=%0d il=%0d expected=8/12", hf, hi);
    else n_pass++;
    read_regs(5'd1, vf, vi);
    n_checks++;
    if (vf !== 32'd10 || vi !== 32'd10) $display("FAIL alu_r1 fwd=%0d il=%0d expected=10", vf, vi);
    else n_pass++;
    read_regs(5'd3, vf, vi);
    n_checks++;
    if (vf !== 32'd30 || vi !== 32'd30) $display("FAIL alu_r3 fwd=%0d il=%0d expected=30", vf, vi);
    else n_pass++;
    read_regs(5'd4, vf, vi);
    n_checks++;
    if (vf !== 32'd900 || vi !== 32'd900) $display("FAIL alu_r4 fwd=%0d il=%0d expected=900", vf, vi);
    else n_pass++;
    n_checks++;
    if (ret_f !== 32'd5 || ret_i !== 32'd5) $display("FAIL alu_retired fwd=%0d il=%0d expected=5", ret_f, ret_i);
    else n_pass++;
  endtask

  task automatic test_store_load_use();
    int hf, hi;
    logic [AW-1:0] pf, pi;
    logic [DW-1:0] vf, vi;
    poke(100, 32'd0);
    prog_buf[0] = enc_ri(OP_ADDI, 5'd1, 5'd0, 16'd7);
    prog_buf[1] = enc_ri(OP_SW, 5'd1, 5'd0, 16'd100);
    prog_buf[2] = enc_ri(OP_LW, 5'd2, 5'd0, 16'd100);
    prog_buf[3] = enc_rr(OP_ADD, 5'd3, 5'd2, 5'd2);
    prog_buf[4] = W_HLT;
    load_prog(5);
    apply_reset();
    run_prog(0, hf, hi, pf, pi);
    n_checks++;
    if (hf !== 9 || hi !== 12) $display("FAIL ldst_halt_edge fwd=%0d il=%0d expected=9/12", hf, hi);
    else n_pass++;
    read_regs(5'd2, vf, vi);
    n_checks++;
    if (vf !== 32'd7 || vi !== 32'd7) $display("FAIL ldst_r2_mem100 fwd=%0d il=%0d expected=7", vf, vi);
    else n_pass++;
    read_regs(5'd3, vf, vi);
    n_checks++;
    if (vf !== 32'd14 || vi !== 32'd14) $display("FAIL ldst_r3 fwd=%0d il=%0d expected=14", vf, vi);
    else n_pass++;
    n_checks++;
    if (ret_f !== 32'd5 || ret_i !== 32'd5) $display("FAIL ldst_retired fwd=%0d il=%0d expected=5", ret_f, ret_i);
    else n_pass++;
  endtask

  task automatic load_loop();
    prog_buf[0] = enc_ri(OP_ADDI, 5'd1, 5'd0, 16'd3);
    prog_buf[1] = enc_ri(OP_SUBI, 5'd1, 5'd1, 16'd1);
    prog_buf[2] = enc_ri(OP_BNEQZ, 5'd0, 5'd1, 16'hFFFE);
    prog_buf[3] = enc_ri(OP_ADDI, 5'd2, 5'd2, 16'd1);
    prog_buf[4] = W_HLT;
    load_prog(5);
  endtask

  task automatic check_loop_results(input string tag);
    int hf, hi;
    logic [AW-1:0] pf, pi;
    logic [DW-1:0] vf, vi;
    run_prog(0, hf, hi, pf, pi);
    n_checks++;
    if (hf !== 16 || hi !== 24) $display("FAIL %s_halt_edge fwd=%0d il=%0d expected=16/24", tag, hf, hi);
    else n_pass++;
    read_regs(5'd1, vf, vi);
    n_checks++;
    if (vf !== 32'd0 || vi !== 32'd0) $display("FAIL %s_r1 fwd=%0d il=%0d expected=0", tag, vf, vi);
    else n_pass++;
    read_regs(5'd2, vf, vi);
    n_checks++;
    if (vf !== 32'd1 || vi !== 32'd1) $display("FAIL %s_r2 fwd=%0d il=%0d expected=1", tag, vf, vi);
    else n_pass++;
    n_checks++;
    if (ret_f !== 32'd9 || ret_i !== 32'd9) $display("FAIL %s_retired fwd=%0d il=%0d expected=9", tag, ret_f, ret_i);
    else n_pass++;
  endtask

  task automatic test_loop_flush();
    load_loop();
    apply_reset();
    check_loop_results("loop");
  endtask

  task automatic test_r0_protect();
    int hf, hi;
    logic [AW-1:0] pf, pi;
    logic [DW-1:0] vf, vi;
    prog_buf[0] = enc_ri(OP_ADDI, 5'd0, 5'd0, 16'd5);
    prog_buf[1] = enc_rr(OP_ADD, 5'd1, 5'd0, 5'd0);
    prog_buf[2] = W_HLT;
    load_prog(3);
    apply_reset();
    run_prog(0, hf, hi, pf, pi);
    n_checks++;
    if (hf !== 6 || hi !== 6) $display("FAIL r0_halt_edge fwd=%0d il=%0d expected=6/6", hf, hi);
    else n_pass++;
    read_regs(5'd1, vf, vi);
    n_checks++;
    if (vf !== 32'd0 || vi !== 32'd0) $display("FAIL r0_r1 fwd=%0d il=%0d expected=0", vf, vi);
    else n_pass++;
    read_regs(5'd0, vf, vi);
    n_checks++;
    if (vf !== 32'd0 || vi !== 32'd0) $display("FAIL r0_r0 fwd=%0d il=%0d expected=0", vf, vi);
    else n_pass++;
    n_checks++;
    if (ret_f !== 32'd3 || ret_i !== 32'd3) $display("FAIL r0_retired fwd=%0d il=%0d expected=3", ret_f, ret_i);
    else n_pass++;
  endtask

  task automatic test_invalid_opcode();
    int hf, hi;
    logic [AW-1:0] pf, pi;
    logic [DW-1:0] vf, vi;
    prog_buf[0] = enc_ri(OP_ADDI, 5'd1, 5'd0, 16'd1);
    prog_buf[1] = 32'h5400_0000;
    prog_buf[2] = enc_ri(OP_ADDI, 5'd2, 5'd0, 16'd1);
    load_prog(3);
    apply_reset();
    run_prog(0, hf, hi, pf, pi);
    n_checks++;
    if (hf !== 5 || hi !== 5) $display("FAIL inv_halt_edge fwd=%0d il=%0d expected=5/5", hf, hi);
    else n_pass++;
    n_checks++;
    if (halt_f !== 1'b1 || halt_i !== 1'b1) $display("FAIL inv_halted fwd=%0b il=%0b expected=1", halt_f, halt_i);
    else n_pass++;
    read_regs(5'd1, vf, vi);
    n_checks++;
    if (vf !== 32'd1 || vi !== 32'd1) $display("FAIL inv_r1 fwd=%0d il=%0d expected=1", vf, vi);
    else n_pass++;
    read_regs(5'd2, vf, vi);
    n_checks++;
    if (vf !== 32'd0 || vi !== 32'd0) $display("FAIL inv_r2 fwd=%0d il=%0d expected=0", vf, vi);
    else n_pass++;
    n_checks++;
    if (ret_f !== 32'd2 || ret_i !== 32'd2) $display("FAIL inv_retired fwd=%0d il=%0d expected=2", ret_f, ret_i);
    else n_pass++;
    n_checks++;
    if (pc_f !== 10'd2 || pc_i !== 10'd2) $display("FAIL inv_pc fwd=%0d il=%0d expected=2", pc_f, pc_i);
    else n_pass++;
  endtask

  task automatic test_pause_resume();
    int hf, hi;
    logic [AW-1:0] pf, pi;
    logic [DW-1:0] vf, vi;
    load_alu_chain();
    apply_reset();
    run_prog(3, hf, hi, pf, pi);
    n_checks++;
    if (pf !== 10'd3 || pi !== 10'd3) $display("FAIL pause_pc fwd=%0d il=%0d expected=3", pf, pi);
    else n_pass++;
    n_checks++;
    if (hf !== 8 || hi !== 12) $display("FAIL pause_halt_edge fwd=%0d il=%0d expected=8/12", hf, hi);
    else n_pass++;
    read_regs(5'd4, vf, vi);
    n_checks++;
    if (vf !== 32'd900 || vi !== 32'd900) $display("FAIL pause_r4 fwd=%0d il=%0d expected=900", vf, vi);
    else n_pass++;
  endtask

  task automatic test_reset_mid_loop();
    logic [DW-1:0] vf, vi;
    load_loop();
    apply_reset();
    @(negedge clk1);
    run = 1'b1;
    repeat (8) @(posedge clk1);
    #3;
    rst_n = 1'b0;
    run = 1'b0;
    #1;
    n_checks++;
    if (pc_f !== '0 || pc_i !== '0) $display("FAIL midrst_pc fwd=%0d il=%0d expected=0", pc_f, pc_i);
    else n_pass++;
    n_checks++;
    if (ret_f !== '0 || ret_i !== '0) $display("FAIL midrst_retired fwd=%0d il=%0d expected=0", ret_f, ret_i);
    else n_pass++;
    n_checks++;
    if (halt_f !== 1'b0 || halt_i !== 1'b0) $display("FAIL midrst_halted fwd=%0b il=%0b expected=0", halt_f, halt_i);
    else n_pass++;
    for (int r = 1; r < 3; r++) begin
      read_regs(5'(r), vf, vi);
      n_checks++;
      if (vf !== '0 || vi !== '0) $display("FAIL midrst_reg%0d fwd=%0d il=%0d expected=0", r, vf, vi);
      else n_pass++;
    end
    @(negedge clk1);
    rst_n = 1'b1;
    check_loop_results("rerun");
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_store_load_use();
    test_loop_flush();
    test_r0_protect();
    test_invalid_opcode();
    test_pause_resume();
    test_reset_mid_loop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
